// File: rtl/text_console_pkg.sv
// Shared definitions for the text console writer and the pixel generator decode.
package text_console_pkg;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int COL_W = 7;
  localparam int ROW_W = 6;

  // Control codes handled by the writer; everything else prints.
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] BS    = 8'h08;
  localparam logic [7:0] FF    = 8'h0C;
  localparam logic [7:0] SPACE = 8'h20;

  // Attribute byte layout {blink, bg[2:0], fg[3:0]}; the RAM word is {attr, code}.
  localparam int ATTR_FG_LSB = 0;
  localparam int ATTR_FG_W   = 4;
  localparam int ATTR_BG_LSB = 4;
  localparam int ATTR_BG_W   = 3;
  localparam int ATTR_BLINK  = 7;
  localparam int WORD_ATTR_LSB = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_CLEAR_LINE,
    ST_CLEAR_SCREEN
  } state_e;

  // Text RAM offset of a cell: row in the upper bits, column in the lower 7.
  function automatic logic [12:0] pack_addr(input logic [ROW_W-1:0] row,
                                            input logic [COL_W-1:0] col);
    return {row, col};
  endfunction

  // Assemble a RAM word from attribute and character code.
  function automatic logic [15:0] pack_word(input logic [7:0] attr,
                                            input logic [7:0] code);
    logic [15:0] w;
    w = '0;
    w[WORD_ATTR_LSB +: 8] = attr;
    w[7:0] = code;
    return w;
  endfunction

  function automatic logic is_ctrl(input logic [7:0] c);
    return (c == CR) || (c == LF) || (c == BS) || (c == FF);
  endfunction

endpackage

// File: rtl/console_cursor.sv
// Cursor position register: applies print/newline/backspace/CR/home commands.
module console_cursor
  import text_console_pkg::*;
#(
  parameter int COLS = 80,
  parameter int ROWS = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,           // printed a character
  input  logic             nl,            // line feed
  input  logic             bs,            // backspace
  input  logic             cr,            // carriage return
  input  logic             home,          // form feed
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row_adv,       // row after an advance, with wrap to 0
  output logic             wrap_pending   // next print wraps to a new line
);

  logic [ROW_W-1:0] row_nxt;
  logic [COL_W-1:0] col_nxt;
  logic             last_col;
  logic             last_row;

  assign last_col     = (col == COL_W'(COLS - 1));
  assign last_row     = (row == ROW_W'(ROWS - 1));
  assign row_adv      = last_row ? '0 : row + ROW_W'(1);
  assign wrap_pending = last_col;

  // Next cursor position from the command strobes (at most one is active).
  always_comb begin
    row_nxt = row;
    col_nxt = col;
    if (home) begin
      row_nxt = '0;
      col_nxt = '0;
    end else if (nl || (adv && last_col)) begin
      row_nxt = row_adv;
      col_nxt = '0;
    end else if (adv) begin
      col_nxt = col + COL_W'(1);
    end else if (cr) begin
      col_nxt = '0;
    end else if (bs) begin
      if (col != '0) begin
        col_nxt = col - COL_W'(1);
      end else if (row != '0) begin
        row_nxt = row - ROW_W'(1);
        col_nxt = COL_W'(COLS - 1);
      end
    end
  end

  // Cursor state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_nxt;
      col <= col_nxt;
    end
  end

endmodule

// File: rtl/text_console_writer.sv
// Character stream to text RAM writer with cursor, control codes and clears.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int          COLS       = 80,
  parameter int          ROWS       = 60,
  parameter logic [14:0] ADDR_TEXT  = 15'd0,
  parameter logic [7:0]  RESET_ATTR = 8'h0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        char_valid,
  input  logic [7:0]  char_data,
  output logic        char_ready,
  input  logic        attr_we,
  input  logic [7:0]  attr_data,
  output logic        wr_en,
  output logic [14:0] wr_addr,
  output logic [15:0] wr_data,
  output logic [6:0]  cursor_col,
  output logic [5:0]  cursor_row,
  output logic        busy
);

  state_e           state, state_nxt;
  logic [7:0]       code_q;
  logic [7:0]       attr, attr_eff;
  logic [7:0]       clr_attr, clr_attr_n;
  logic [ROW_W-1:0] clr_row, clr_row_n;
  logic [COL_W-1:0] clr_col, clr_col_n;
  logic             clr_done, clr_done_n;

  logic             take;
  logic             wr_en_n;
  logic [14:0]      wr_addr_n;
  logic [15:0]      wr_data_n;

  // Clear-word issue request, shared by clear entry (EXEC) and the clear states.
  logic             iss, iss_screen, iss_last_col;
  logic [ROW_W-1:0] iss_row;
  logic [COL_W-1:0] iss_col;
  logic [7:0]       iss_attr;

  logic             c_adv, c_nl, c_bs, c_cr, c_home;
  logic [ROW_W-1:0] cur_row, row_adv;
  logic [COL_W-1:0] cur_col;
  logic             wrap_pending;

  // A same-cycle attr_we is seen by the character transferred in that cycle.
  assign attr_eff = attr_we ? attr_data : attr;

  console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
    .clk          (clk),
    .reset        (reset),
    .adv          (c_adv),
    .nl           (c_nl),
    .bs           (c_bs),
    .cr           (c_cr),
    .home         (c_home),
    .row          (cur_row),
    .col          (cur_col),
    .row_adv      (row_adv),
    .wrap_pending (wrap_pending)
  );

  // Next state, cursor commands and the next registered write.
  always_comb begin
    state_nxt    = state;
    take         = 1'b0;
    c_adv        = 1'b0;
    c_nl         = 1'b0;
    c_bs         = 1'b0;
    c_cr         = 1'b0;
    c_home       = 1'b0;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;
    iss          = 1'b0;
    iss_screen   = 1'b0;
    iss_row      = clr_row;
    iss_col      = clr_col;
    iss_attr     = clr_attr;
    iss_last_col = 1'b0;
    clr_attr_n   = clr_attr;
    clr_row_n    = clr_row;
    clr_col_n    = clr_col;
    clr_done_n   = clr_done;

    case (state)
      ST_IDLE: begin
        if (char_valid) begin
          take      = 1'b1;
          state_nxt = ST_EXEC;
          // The print write is registered here so it is on the bus during EXEC.
          if (!is_ctrl(char_data)) begin
            wr_en_n   = 1'b1;
            wr_addr_n = ADDR_TEXT + {2'b00, pack_addr(cur_row, cur_col)};
            wr_data_n = pack_word(attr_eff, char_data);
          end
        end
      end
      ST_EXEC: begin
        state_nxt = ST_IDLE;
        case (code_q)
          CR: c_cr = 1'b1;
          BS: c_bs = 1'b1;
          LF: begin
            c_nl       = 1'b1;
            state_nxt  = ST_CLEAR_LINE;
            iss        = 1'b1;
            iss_row    = row_adv;
            iss_col    = '0;
            iss_attr   = attr_eff;
            clr_attr_n = attr_eff;
          end
          FF: begin
            c_home     = 1'b1;
            state_nxt  = ST_CLEAR_SCREEN;
            iss        = 1'b1;
            iss_screen = 1'b1;
            iss_row    = '0;
            iss_col    = '0;
            iss_attr   = attr_eff;
            clr_attr_n = attr_eff;
          end
          default: begin
            c_adv = 1'b1;
            if (wrap_pending) begin
              state_nxt  = ST_CLEAR_LINE;
              iss        = 1'b1;
              iss_row    = row_adv;
              iss_col    = '0;
              iss_attr   = attr_eff;
              clr_attr_n = attr_eff;
            end
          end
        endcase
      end
      ST_CLEAR_LINE, ST_CLEAR_SCREEN: begin
        if (clr_done) begin
          state_nxt = ST_IDLE;
        end else begin
          iss        = 1'b1;
          iss_screen = (state == ST_CLEAR_SCREEN);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Issue one space word and step the clear position row-major.
    if (iss) begin
      wr_en_n      = 1'b1;
      wr_addr_n    = ADDR_TEXT + {2'b00, pack_addr(iss_row, iss_col)};
      wr_data_n    = pack_word(iss_attr, SPACE);
      iss_last_col = (iss_col == COL_W'(COLS - 1));
      if (iss_last_col) begin
        clr_col_n = '0;
        clr_row_n = iss_row + ROW_W'(1);
      end else begin
        clr_col_n = iss_col + COL_W'(1);
        clr_row_n = iss_row;
      end
      clr_done_n = iss_last_col && (!iss_screen || (iss_row == ROW_W'(ROWS - 1)));
    end
  end

  // Registered state, attribute, clear counters and all outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      code_q     <= '0;
      attr       <= RESET_ATTR;
      clr_attr   <= '0;
      clr_row    <= '0;
      clr_col    <= '0;
      clr_done   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      char_ready <= 1'b1;
      busy       <= 1'b0;
      cursor_col <= '0;
      cursor_row <= '0;
    end else begin
      state      <= state_nxt;
      if (take) code_q <= char_data;
      attr       <= attr_eff;
      clr_attr   <= clr_attr_n;
      clr_row    <= clr_row_n;
      clr_col    <= clr_col_n;
      clr_done   <= clr_done_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      char_ready <= (state_nxt == ST_IDLE);
      busy       <= (state_nxt != ST_IDLE);
      cursor_col <= cur_col;
      cursor_row <= cur_row;
    end
  end

endmodule
